uart_tx_arbiter: RTL and testbench

// - Shares the single UART transmitter among N result producers (AND units, status sources).
// - Round-robin grants one requester at a time, serialises its M-bit word into M/8 bytes
//   (LSB byte first) and sequences the transmitter's load/enable/done handshake.
// - Enforces an inter-frame gap so the host can keep up between frames.

---
 rtl/uart_tx_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter among N word producers.
// Optional per-byte TxDone timeout enabled by defining TXARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned M       = 8,
    parameter int unsigned GAP     = 100000,
    parameter int unsigned TIMEOUT = 200000
) (
    input  logic             clk,
    input  logic             RstArb,
    input  logic [N-1:0]     Req,
    input  logic [N*M-1:0]   Data,
    output logic [N-1:0]     Grant,
    output logic [N-1:0]     Done,
    output logic [7:0]       TxData,
    output logic             TxLoad,
    output logic             TxEn,
    input  logic             TxDone,
    output logic             Busy,
    output logic             Abort
);

    localparam int unsigned NB = M / 8;
    localparam int unsigned BW = $clog2(NB + 1);
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    if (N < 2 || N > 8) begin : g_bad_n
        $error("uart_tx_arbiter: N must be 2..8");
    end
    if (M < 8 || (M % 8) != 0) begin : g_bad_m
        $error("uart_tx_arbiter: M must be a multiple of 8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {StIdle, StLoad, StSend, StDone, StGap} state_e;

    state_e          state_q;
    logic [M-1:0]    word_q;
    logic [BW-1:0]   bcnt_q;
    logic [GW-1:0]   gcnt_q;
    logic [PW-1:0]   ptr_q;
    logic [N-1:0]    grant_q;
    logic [N-1:0]    done_q;
    logic [7:0]      tx_data_q;
    logic            tx_load_q;
    logic            tx_en_q;
    logic            busy_q;

    logic [PW-1:0]   win;
    logic [PW-1:0]   idx;
    logic [N-1:0]    win_oh;
    logic [M-1:0]    win_word;
    logic [M-1:0]    word_shift;
    logic            found;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win    = ptr_q;
        idx    = '0;
        win_oh = '0;
        found  = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = PW'((32'(ptr_q) + off) % N);
            if (!found && Req[idx]) begin
                found       = 1'b1;
                win         = idx;
                win_oh      = '0;
                win_oh[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        win_word = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (win == PW'(i)) win_word = Data[i*M +: M];
        end
        word_shift = word_q >> 8;
    end

`ifdef TXARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_q;
    logic          abort_q;
    assign Abort = abort_q;
`else
    assign Abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (RstArb) begin
            state_q   <= StIdle;
            word_q    <= '0;
            bcnt_q    <= '0;
            gcnt_q    <= '0;
            ptr_q     <= PW'(N - 1);
            grant_q   <= '0;
            done_q    <= '0;
            tx_data_q <= '0;
            tx_load_q <= 1'b0;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef TXARB_TIMEOUT_EN
            tcnt_q    <= '0;
            abort_q   <= 1'b0;
`endif
        end else begin
            done_q    <= '0;
            tx_load_q <= 1'b0;
`ifdef TXARB_TIMEOUT_EN
            abort_q   <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        word_q    <= win_word;
                        tx_data_q <= win_word[7:0];
                        tx_load_q <= 1'b1;
                        bcnt_q    <= BW'(NB);
                        grant_q   <= win_oh;
                        ptr_q     <= win;
                        busy_q    <= 1'b1;
                        state_q   <= StLoad;
                    end
                end
                StLoad: begin
                    tx_en_q <= 1'b1;
                    state_q <= StSend;
`ifdef TXARB_TIMEOUT_EN
                    tcnt_q  <= '0;
`endif
                end
                StSend: begin
                    if (TxDone) begin
                        tx_en_q <= 1'b0;
                        if (bcnt_q > BW'(1)) begin
                            word_q    <= word_shift;
                            tx_data_q <= word_shift[7:0];
                            tx_load_q <= 1'b1;
                            bcnt_q    <= bcnt_q - BW'(1);
                            state_q   <= StLoad;
                        end else begin
                            done_q  <= grant_q;
                            state_q <= StDone;
                        end
                    end
`ifdef TXARB_TIMEOUT_EN
                    else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        tx_en_q <= 1'b0;
                        abort_q <= 1'b1;
                        done_q  <= grant_q;
                        state_q <= StDone;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
`endif
                end
                StDone: begin
                    grant_q <= '0;
                    gcnt_q  <= '0;
                    if (GAP == 0) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (gcnt_q == GW'(GAP - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        gcnt_q <= gcnt_q + GW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Grant  = grant_q;
    assign Done   = done_q;
    assign TxData = tx_data_q;
    assign TxLoad = tx_load_q;
    assign TxEn   = tx_en_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with N=4, M=16, GAP=4, TIMEOUT=10.
module tb_uart_tx_arbiter;

    localparam int unsigned N       = 4;
    localparam int unsigned M       = 16;
    localparam int unsigned GAP     = 4;
    localparam int unsigned TIMEOUT = 10;

    logic           clk = 1'b0;
    logic           RstArb;
    logic [N-1:0]   Req;
    logic [N*M-1:0] Data;
    logic [N-1:0]   Grant;
    logic [N-1:0]   Done;
    logic [7:0]     TxData;
    logic           TxLoad;
    logic           TxEn;
    logic           TxDone;
    logic           Busy;
    logic           Abort;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N       (N),
        .M       (M),
        .GAP     (GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .RstArb (RstArb),
        .Req    (Req),
        .Data   (Data),
        .Grant  (Grant),
        .Done   (Done),
        .TxData (TxData),
        .TxLoad (TxLoad),
        .TxEn   (TxEn),
        .TxDone (TxDone),
        .Busy   (Busy),
        .Abort  (Abort)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame: waits for a grant, answers every byte with TxDone, returns when idle.
    task automatic serve(output logic [N-1:0] g, output int dones, output int loads);
        g     = '0;
        dones = 0;
        loads = 0;
        for (int i = 0; i < 50 && Grant === '0; i++) tick();
        g = Grant;
        for (int i = 0; i < 60 && Busy === 1'b1; i++) begin
            if (TxLoad) loads++;
            if (Done !== '0) begin
                dones++;
                if (Done !== g) dones += 100;
            end
            TxDone = TxEn;
            tick();
        end
        TxDone = 1'b0;
    endtask

    logic [N-1:0] g;
    logic [N-1:0] exp_g;
    int           d;
    int           l;

    initial begin
        RstArb = 1'b1;
        Req    = '0;
        Data   = '0;
        TxDone = 1'b0;
        tick();
        tick();
        RstArb = 1'b0;

        // Reset in the middle of random traffic
        for (int i = 0; i < 30; i++) begin
            Req    = N'($urandom);
            Data   = {$urandom(), $urandom()};
            TxDone = 1'($urandom_range(0, 1));
            tick();
        end
        RstArb = 1'b1;
        tick();
        chk("rst_outs_1", 32'({Grant, Done, TxData, TxLoad, TxEn, Busy, Abort}), 32'h0);
        tick();
        chk("rst_outs_2", 32'({Grant, Done, TxData, TxLoad, TxEn, Busy, Abort}), 32'h0);
        RstArb = 1'b0;
        Req    = '0;
        TxDone = 1'b0;
        Data   = {16'h3333, 16'hA55A, 16'h1111, 16'h0000};
        tick();
        chk("idle_after_rst", 32'(Busy), 32'h0);

        // Fairness: all requesting, expect 0,1,2,3,0
        Req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            exp_g = N'(1) << (f % 4);
            serve(g, d, l);
            chk("fair_grant", 32'(g), 32'(exp_g));
            chk("fair_done", 32'(d), 32'd1);
            chk("fair_loads", 32'(l), 32'd2);
            chk("fair_idle", 32'(Busy), 32'h0);
        end
        Req = '0;
        tick();

        // Single frame, fully directed cycle by cycle
        Req = 4'b0100;
        tick();
        chk("s_grant", 32'(Grant), 32'h4);
        chk("s_load0", 32'({TxLoad, TxEn, Busy}), 32'b101);
        chk("s_byte0", 32'(TxData), 32'h5A);
        Req = '0;
        tick();
        chk("s_send0", 32'({TxLoad, TxEn}), 32'b01);
        TxDone = 1'b1;
        tick();
        TxDone = 1'b0;
        chk("s_load1", 32'({TxLoad, TxEn}), 32'b10);
        chk("s_byte1", 32'(TxData), 32'hA5);
        tick();
        chk("s_send1", 32'(TxEn), 32'h1);
        TxDone = 1'b1;
        tick();
        TxDone = 1'b0;
        chk("s_done", 32'(Done), 32'h4);
        chk("s_done_txen", 32'({TxEn, Busy, Abort}), 32'b010);
        tick();
        chk("s_gap", 32'({Grant, Done, Busy}), 32'h1);
        tick();
        tick();
        tick();
        chk("s_gap_end", 32'(Busy), 32'h1);
        tick();
        chk("s_idle", 32'(Busy), 32'h0);

        // Rotation: serve 1, then 1 and 3 together -> 3 before 1
        Req = 4'b0010;
        serve(g, d, l);
        chk("rot_first", 32'(g), 32'h2);
        Req = 4'b1010;
        serve(g, d, l);
        chk("rot_second", 32'(g), 32'h8);
        serve(g, d, l);
        chk("rot_third", 32'(g), 32'h2);
        Req = '0;
        tick();

        // Reset while a byte is in flight
        Req = 4'b0100;
        for (int i = 0; i < 20 && TxEn !== 1'b1; i++) tick();
        chk("rs_in_send", 32'(TxEn), 32'h1);
        RstArb = 1'b1;
        Req    = 4'b0011;
        tick();
        chk("rs_outs", 32'({Grant, TxLoad, TxEn, Busy}), 32'h0);
        RstArb = 1'b0;
        serve(g, d, l);
        chk("rs_first", 32'(g), 32'h1);
        serve(g, d, l);
        chk("rs_second", 32'(g), 32'h2);
        Req = '0;
        tick();

        // Transmitter never answers
        Data = {16'hBEEF, 16'h2222, 16'h1111, 16'h0000};
        Req  = 4'b1000;
        for (int i = 0; i < 20 && Grant === '0; i++) tick();
        chk("to_grant", 32'(Grant), 32'h8);
        chk("to_byte0", 32'(TxData), 32'hEF);
        Req = '0;
        tick();
        chk("to_send", 32'(TxEn), 32'h1);
`ifdef TXARB_TIMEOUT_EN
        for (int i = 1; i < 10; i++) begin
            tick();
            chk("to_wait", 32'({TxEn, Abort}), 32'b10);
        end
        tick();
        chk("to_abort", 32'({TxEn, Abort}), 32'b01);
        chk("to_done", 32'(Done), 32'h8);
        tick();
        chk("to_abort_pulse", 32'({Abort, Done}), 32'h0);
        for (int i = 0; i < 20 && Busy === 1'b1; i++) tick();
        chk("to_recover", 32'(Busy), 32'h0);
`else
        for (int i = 0; i < 1000; i++) begin
            tick();
            chk("noto_hold", 32'({TxEn, Abort}), 32'b10);
        end
        RstArb = 1'b1;
        tick();
        RstArb = 1'b0;
        chk("noto_reset", 32'({TxEn, Busy}), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
